// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the writeback arbiter and its bench.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// after rr_ptr, wrapping around. Shared with the data-memory port arbiter.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         grant
);

  logic found;

  // Search the upper slice [rr_ptr..NREQ-1] first, then the wrapped slice [0..rr_ptr-1].
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(rr_ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i < int'(rr_ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single registered write port.
// Optional decode-stage bypass outputs are built when REGARB_FWD_EN is defined.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        writeReg,
  output logic [DATA_W-1:0]        writeData,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
`ifdef REGARB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]        fwd_rd_addr1,
  input  logic [ADDR_W-1:0]        fwd_rd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data
`endif
);

  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]   grant;
  logic              xfer;
  logic [GW-1:0]     sel_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic [GW-1:0]     rr_ptr_q,     rr_ptr_d;
  logic              reg_write_q,  reg_write_d;
  logic [ADDR_W-1:0] write_reg_q,  write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [GW-1:0]     grant_id_q,   grant_id_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (grant)
  );

  always_comb begin
    sel_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_idx  = GW'(i);
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer = |(grant & req_valid);

  // Writes to register 0 still complete the handshake but never raise RegWrite.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    if (xfer) begin
      reg_write_d  = (sel_addr != ADDR_W'(REG_ZERO));
      write_reg_d  = sel_addr;
      write_data_d = sel_data;
      grant_id_d   = sel_idx;
      rr_ptr_d     = (sel_idx == GW'(NREQ - 1)) ? '0 : sel_idx + GW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      grant_id_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign req_ready = grant;
  assign busy      = |req_valid;
  assign RegWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign grant_id  = grant_id_q;

`ifdef REGARB_FWD_EN
  // Bypass for a decode-stage read of the register being written on this negedge.
  assign fwd_hit1 = reg_write_q & (write_reg_q == fwd_rd_addr1) & (write_reg_q != ADDR_W'(REG_ZERO));
  assign fwd_hit2 = reg_write_q & (write_reg_q == fwd_rd_addr2) & (write_reg_q != ADDR_W'(REG_ZERO));
  assign fwd_data = write_data_q;
`else
  // No bypass ports or comparators in this build.
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: queue-based requesters, a
// round-robin reference model, and a negedge monitor checking the write port.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int NREQ   = 2;
  localparam int ADDR_W = REG_ADDR_W;
  localparam int DATA_W = REG_DATA_W;

  logic                    CLK = 1'b0;
  logic                    RST_N;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*ADDR_W-1:0]  req_addr;
  logic [NREQ*DATA_W-1:0]  req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    RegWrite;
  logic [ADDR_W-1:0]       writeReg;
  logic [DATA_W-1:0]       writeData;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                    busy;
`ifdef REGARB_FWD_EN
  logic [ADDR_W-1:0]       fwd_rd_addr1;
  logic [ADDR_W-1:0]       fwd_rd_addr2;
  logic                    fwd_hit1;
  logic                    fwd_hit2;
  logic [DATA_W-1:0]       fwd_data;
`endif

  regfile_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .RegWrite  (RegWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef REGARB_FWD_EN
    ,
    .fwd_rd_addr1 (fwd_rd_addr1),
    .fwd_rd_addr2 (fwd_rd_addr2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data     (fwd_data)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] wdata;
    int                gid;
  } exp_t;

  wb_req_t           pend_q [NREQ][$];
  exp_t              exp_q[$];
  int                n_vec = 0;
  int                n_err = 0;
  int                m_ptr;
  logic              m_rw;
  logic [ADDR_W-1:0] m_wreg;
  logic [DATA_W-1:0] m_wdata;
  int                m_gid;
  logic [DATA_W-1:0] dut_rf   [32];
  logic [DATA_W-1:0] model_rf [32];
  logic              fwd_force = 1'b0;
  logic [ADDR_W-1:0] fwd_a1_f  = '0;
  logic [ADDR_W-1:0] fwd_a2_f  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic enqueue(input int id, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    wb_req_t r;
    r.valid = 1'b1;
    r.addr  = addr;
    r.data  = data;
    pend_q[id].push_back(r);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (pend_q[i].size() > 0) begin
        req_valid[i]                   = 1'b1;
        req_addr[i*ADDR_W +: ADDR_W]   = pend_q[i][0].addr;
        req_data[i*DATA_W +: DATA_W]   = pend_q[i][0].data;
      end else begin
        req_valid[i]                   = 1'b0;
        req_addr[i*ADDR_W +: ADDR_W]   = ADDR_W'($urandom);
        req_data[i*DATA_W +: DATA_W]   = $urandom;
      end
    end
  endtask

  // Reference grant: first requester with pending work, scanning from m_ptr modulo NREQ.
  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (pend_q[idx].size() > 0) return idx;
    end
    return -1;
  endfunction

  function automatic logic any_pending();
    for (int i = 0; i < NREQ; i++) if (pend_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_rw    = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
    m_gid   = 0;
    exp_q.delete();
  endtask

  // One clock cycle, entered and left on a negedge.
  task automatic apply_stimulus();
    int      g;
    logic [63:0] exp_ready;
    wb_req_t r;
    drive_inputs();
    #1;
    g         = model_grant();
    exp_ready = (g >= 0) ? (64'd1 << g) : 64'd0;
    check("req_ready", 64'(req_ready), exp_ready);
    check("busy", 64'(busy), 64'(any_pending()));
    @(posedge CLK);
    if (RST_N) begin
      if (g >= 0) begin
        r       = pend_q[g].pop_front();
        m_rw    = (r.addr != 0);
        m_wreg  = r.addr;
        m_wdata = r.data;
        m_gid   = g;
        m_ptr   = (g + 1) % NREQ;
      end else begin
        m_rw = 1'b0;
      end
      exp_q.push_back('{m_rw, m_wreg, m_wdata, m_gid});
    end
    @(negedge CLK);
  endtask

  task automatic check_output_reset(input string tag);
    check({tag, "_RegWrite"},  64'(RegWrite),  64'd0);
    check({tag, "_writeReg"},  64'(writeReg),  64'd0);
    check({tag, "_writeData"}, 64'(writeData), 64'd0);
    check({tag, "_grant_id"},  64'(grant_id),  64'd0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    drive_inputs();
    #1;
    check_output_reset("reset");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Monitor: pops one expected port state per accepted clock and compares it at the negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("RegWrite",  64'(RegWrite),  64'(e.rw));
        check("writeReg",  64'(writeReg),  64'(e.wreg));
        check("writeData", 64'(writeData), 64'(e.wdata));
        check("grant_id",  64'(grant_id),  64'(e.gid));
        if (RegWrite) dut_rf[writeReg] = writeData;
        if (e.rw) model_rf[e.wreg] = e.wdata;
`ifdef REGARB_FWD_EN
        if (fwd_force) begin
          fwd_rd_addr1 = fwd_a1_f;
          fwd_rd_addr2 = fwd_a2_f;
        end else begin
          fwd_rd_addr1 = ($urandom_range(0, 1) == 1) ? e.wreg : ADDR_W'($urandom);
          fwd_rd_addr2 = ($urandom_range(0, 3) == 0) ? e.wreg : ADDR_W'($urandom);
        end
        #1;
        check("fwd_hit1", 64'(fwd_hit1), 64'(e.rw && (e.wreg == fwd_rd_addr1) && (e.wreg != 0)));
        check("fwd_hit2", 64'(fwd_hit2), 64'(e.rw && (e.wreg == fwd_rd_addr2) && (e.wreg != 0)));
        check("fwd_data", 64'(fwd_data), 64'(e.wdata));
`endif
      end
    end
  end

  always @(posedge CLK) begin
    if (RST_N === 1'b1)
      assert (!$isunknown(req_valid)) else $error("[TB] FAIL x_req_valid: got %b, required known bits", req_valid);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    for (int r = 0; r < 32; r++) begin
      dut_rf[r]   = '0;
      model_rf[r] = '0;
    end
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
`ifdef REGARB_FWD_EN
    fwd_rd_addr1 = '0;
    fwd_rd_addr2 = '0;
`endif
    RST_N = 1'b0;
    @(negedge CLK);
    do_reset();

    // Single write from requester 0, then an idle cycle.
    enqueue(0, 5'd5, 32'h1234);
    repeat (3) apply_stimulus();

    // Both requesters busy for four cycles from a fresh pointer: grants 0,1,0,1.
    do_reset();
    enqueue(0, 5'd1, 32'hA); enqueue(0, 5'd1, 32'hA);
    enqueue(1, 5'd2, 32'hB); enqueue(1, 5'd2, 32'hB);
    repeat (5) apply_stimulus();

    // Register-0 write is handshaken but not written.
    enqueue(1, 5'd0, 32'hFFFF_FFFF);
    repeat (2) apply_stimulus();

    // Move the pointer to 1, then both hit register 7: req1 first, req0 last.
    enqueue(0, 5'd3, 32'h33);
    apply_stimulus();
    enqueue(0, 5'd7, 32'd1);
    enqueue(1, 5'd7, 32'd2);
    repeat (3) apply_stimulus();
    check("rf7_last_write_wins", 64'(dut_rf[7]), 64'd1);
    check("rf0_stays_zero", 64'(dut_rf[0]), 64'd0);

    // Reset mid-cycle while a write is on the port; held requests resume from pointer 0.
    enqueue(0, 5'd4, 32'hDEAD);
    enqueue(0, 5'd6, 32'hBEEF);
    enqueue(1, 5'd8, 32'hCAFE);
    apply_stimulus();
    #1;
    check("pre_reset_RegWrite", 64'(RegWrite), 64'd1);
    #1;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_output_reset("async_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) apply_stimulus();

`ifdef REGARB_FWD_EN
    fwd_force = 1'b1;
    fwd_a1_f  = 5'd9;
    fwd_a2_f  = 5'd0;
    enqueue(0, 5'd9, 32'd77);
    repeat (2) apply_stimulus();
    fwd_force = 1'b0;
`endif

    // Randomized traffic with occasional register-0 targets.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 2) == 0 && pend_q[i].size() < 4) begin
          if ($urandom_range(0, 7) == 0) enqueue(i, 5'd0, $urandom);
          else enqueue(i, ADDR_W'($urandom), $urandom);
        end
      end
      apply_stimulus();
    end

    budget = 0;
    while (any_pending() && budget < 50) begin
      apply_stimulus();
      budget++;
    end
    check("drain_pending", 64'(any_pending()), 64'd0);
    repeat (2) apply_stimulus();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    for (int r = 0; r < 32; r++) check("regfile_contents", 64'(dut_rf[r]), 64'(model_rf[r]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (RegWrite / writeReg / writeData) between NREQ writeback requesters, e.g. requester 0 = ALU writeback, requester 1 = load writeback.
- Round-robin grant with a valid/ready handshake per requester.
- The write port is registered on posedge CLK, so it is stable when the register file samples it on negedge CLK.
- Writes to register 0 are handshaken but suppressed, so register 0 stays hard zero.

Parameters:
- NREQ, 2, number of writeback requesters (2..8).
- ADDR_W, 5, register index width.
- DATA_W, 32, write data width.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*ADDR_W  flattened target register indices; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NREQ*DATA_W  flattened write data, packed the same way.
- req_ready  out  NREQ  one-hot grant, combinational; transfer = valid & ready at posedge.
- RegWrite  out  1  register-file write enable, registered.
- writeReg  out  ADDR_W  register-file write index, registered.
- writeData  out  DATA_W  register-file write data, registered.
- grant_id  out  $clog2(NREQ)  index of the requester whose write is on the port, registered.
- busy  out  1  at least one req_valid asserted this cycle, combinational.

Behaviour:
- Reset (async, RST_N=0):
  - RegWrite=0, writeReg=0, writeData=0, grant_id=0.
  - Round-robin pointer rr_ptr=0, meaning requester 0 has highest priority.
  - Outputs hold these values until the first posedge after RST_N deasserts.
- Grant (combinational):
  - Search req_valid starting at index rr_ptr and wrapping modulo NREQ.
  - The first valid index gets req_ready=1; all others get 0.
  - At most one ready bit is set; none when no request is valid.
- Accept (posedge, when any transfer occurs, granted index g):
  - writeReg<=req_addr[g], writeData<=req_data[g], grant_id<=g.
  - RegWrite<=(req_addr[g]!=0).
  - rr_ptr<=(g+1) mod NREQ.
- Idle (posedge, no transfer): RegWrite<=0. writeReg, writeData and grant_id hold; rr_ptr holds.
- Latency and throughput:
  - Exactly one cycle from accept to RegWrite high.
  - RegWrite is high for exactly one cycle per accepted non-zero write.
  - One write per cycle sustained.
- Requester rules:
  - A requester must hold valid, addr and data stable until ready.
  - The arbiter never drops or reorders a single requester's writes.
- Same target, same cycle: if two requesters target the same register, both are serviced in successive cycles in round-robin order. The last write wins in the register file.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1. Maximum wait is NREQ-1 cycles.
- Reset mid-operation: the in-flight registered write is discarded (RegWrite forced to 0 asynchronously). Un-granted requests are retried after reset.
- Input sanitation: no X-propagation into RegWrite. req_valid bits that are X are treated as a design error and flagged only by assertions in the bench.

Optional Feature:
- Macro: REGARB_FWD_EN.
- Defined:
  - Adds inputs fwd_rd_addr1 and fwd_rd_addr2 (ADDR_W each).
  - Adds outputs fwd_hit1, fwd_hit2 (1 each) and fwd_data (DATA_W).
  - fwd_hitN = RegWrite & (writeReg==fwd_rd_addrN) & (writeReg!=0).
  - fwd_data = writeData.
  - This lets the decode stage bypass the write that lands on the current negedge.
- Undefined: those ports do not exist and no comparators are built.

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0.
  - A wb_req struct typedef {valid, addr, data}.
- One natural sub-module, rr_arbiter:
  - Parameterised on NREQ.
  - Inputs: request vector and rr_ptr. Output: one-hot grant.
  - Purely combinational, reused later for the data-memory port.
- The top level holds rr_ptr, the output register and the optional forwarding logic.

Test Plan:
- Reset, then req0 valid addr=5 data=32'h1234 -> req_ready=2'b01 that cycle. Next cycle RegWrite=1, writeReg=5, writeData=32'h1234, grant_id=0. RegWrite=0 the cycle after.
- Both valid for 4 cycles (req0 addr=1,data=0xA; req1 addr=2,data=0xB) -> grants alternate 0,1,0,1, starting at 0 after reset. RegWrite high 4 consecutive cycles.
- req1 valid addr=0 data=32'hFFFF_FFFF -> req_ready[1]=1 and grant_id=1 next cycle, but RegWrite stays 0.
- Both target addr=7, req0 data=1, req1 data=2, rr_ptr=1 -> req1 written first, then req0. Final register[7]=1.
- Assert RST_N=0 mid-cycle while RegWrite=1 -> RegWrite drops immediately without waiting for a clock edge. After release, a held req0 is granted with rr_ptr=0.
- REGARB_FWD_EN defined, write addr=9 data=77 in flight, fwd_rd_addr1=9, fwd_rd_addr2=0 -> fwd_hit1=1, fwd_hit2=0, fwd_data=77.
